// File: rtl/injection_latch_array_pkg.sv
// Shared definitions for the injection latch array: per-channel state
// encoding and the sizing helper for the hold-off counter.
// Optional feature macro: INJ_EVT_CNT_EN (used by the channel module).
package injection_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } inj_state_t;

  // Bits needed to represent values up to n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/injection_latch_array_if.sv
// Bundle of the trigger inputs and observation outputs of the latch array.
// There is no valid/ready handshake on this bus: every input is sampled on
// every rising clk edge, and every output is a registered (or OR-reduced
// registered) value valid for the whole cycle after the edge.
// dbg_state carries each channel's FSM state (2 bits per channel) for checkers.
interface injection_latch_array_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  logic                    clear_i;
  logic [NUM_CH-1:0]       mode_i;
  logic [NUM_CH-1:0]       set_i;
  logic [NUM_CH-1:0]       gate_i;
  logic [NUM_CH-1:0]       out_o;
  logic                    any_o;
  logic [NUM_CH*CNT_W-1:0] evt_cnt_o;
  logic [2*NUM_CH-1:0]     dbg_state;

  modport master (
    output clear_i, mode_i, set_i, gate_i,
    input  out_o, any_o, evt_cnt_o, dbg_state
  );

  modport slave (
    input  clear_i, mode_i, set_i, gate_i,
    output out_o, any_o, evt_cnt_o, dbg_state
  );
endinterface

// File: rtl/injection_latch_array_channel.sv
// One injection channel: IDLE/ACTIVE/HOLD FSM with a registered flag, an
// optional hold-off countdown after the qualifying condition drops, and an
// optional saturating count of IDLE->ACTIVE entries.
// Optional feature macro: INJ_EVT_CNT_EN (event counter present when defined,
// otherwise evt_cnt is tied to zero).
module injection_channel
  import injection_pkg::*;
#(
  parameter int HOLD_CYCLES = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             mode,
  input  logic             set,
  input  logic             gate,
  output logic             out,
  output logic [CNT_W-1:0] evt_cnt,
  output inj_state_t       state_dbg
);

  localparam int HW = clog2_min1(HOLD_CYCLES + 1);
  // Countdown start value; the HOLD state itself accounts for one cycle.
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  inj_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic          q;

  // Sticky channels keep themselves alive through their own flag; level
  // channels need a fresh set every cycle. The gate qualifies both.
  assign q = gate & (set | (mode & out));

  assign state_dbg = state;

  // Channel FSM with registered flag and hold-off countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      out      <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      hold_cnt <= '0;
      out      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (q) begin
            state <= ACTIVE;
            out   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!q) begin
            if (HOLD_CYCLES == 0) begin
              state <= IDLE;
              out   <= 1'b0;
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          if (q) begin
            state <= ACTIVE;
          end else if (hold_cnt == '0) begin
            state <= IDLE;
            out   <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          out   <= 1'b0;
        end
      endcase
    end
  end

`ifdef INJ_EVT_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             start;

  // Only a fresh capture from IDLE counts; re-entry from HOLD does not.
  assign start = (state == IDLE) & q;

  // Saturating event counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (start && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign evt_cnt = cnt_q;
`else
  assign evt_cnt = '0;
`endif

endmodule

// File: rtl/injection_latch_array.sv
// N-channel injection latch array: one independent injection_channel per
// channel plus the any_o summary flag.
// Optional feature macro: INJ_EVT_CNT_EN (per-channel event counters).
module injection_latch_array
  import injection_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int HOLD_CYCLES = 0,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  injection_latch_array_if.slave bus
);

  logic [NUM_CH-1:0]       out_vec;
  logic [NUM_CH*CNT_W-1:0] cnt_vec;
  inj_state_t              ch_state [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    injection_channel #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .clear     (bus.clear_i),
      .mode      (bus.mode_i[k]),
      .set       (bus.set_i[k]),
      .gate      (bus.gate_i[k]),
      .out       (out_vec[k]),
      .evt_cnt   (cnt_vec[k*CNT_W +: CNT_W]),
      .state_dbg (ch_state[k])
    );

    assign bus.dbg_state[2*k +: 2] = ch_state[k];
  end

  assign bus.out_o     = out_vec;
  assign bus.evt_cnt_o = cnt_vec;
  // Summary flag straight off the channel registers, no extra latency.
  assign bus.any_o     = |out_vec;

endmodule

// File: tb/tb_injection_latch_array.sv
// Bench for injection_latch_array. Two instances share the same stimulus:
// dut_a (HOLD_CYCLES=0, CNT_W=8) and dut_b (HOLD_CYCLES=3, CNT_W=2).
// Builds with or without INJ_EVT_CNT_EN; expected counters are zero without it.
module tb_injection_latch_array;
  import injection_pkg::*;

  localparam int NUM_CH  = 2;
  localparam int HOLD_A  = 0;
  localparam int CNT_W_A = 8;
  localparam int HOLD_B  = 3;
  localparam int CNT_W_B = 2;
`ifdef INJ_EVT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  injection_latch_array_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W_A)) bus_a ();
  injection_latch_array_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W_B)) bus_b ();

  injection_latch_array #(.NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD_A), .CNT_W(CNT_W_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  injection_latch_array #(.NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD_B), .CNT_W(CNT_W_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;

  // Reference model: flag, cycles since the condition was last true, event count.
  int hold_p [2] = '{HOLD_A, HOLD_B};
  int cmax   [2] = '{(1 << CNT_W_A) - 1, (1 << CNT_W_B) - 1};
  bit m_out  [2][NUM_CH];
  int m_age  [2][NUM_CH];
  int m_cnt  [2][NUM_CH];

  logic              cur_clear;
  logic [NUM_CH-1:0] cur_mode, cur_set, cur_gate;

  typedef struct {
    logic       clear;
    logic [1:0] mode;
    logic [1:0] set;
    logic [1:0] gate;
    logic [1:0] exp_out;
    logic [7:0] exp_c0;
    logic [7:0] exp_c1;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic c, input logic [1:0] m, input logic [1:0] s, input logic [1:0] g);
    cur_clear = c; cur_mode = m; cur_set = s; cur_gate = g;
    bus_a.clear_i = c; bus_a.mode_i = m; bus_a.set_i = s; bus_a.gate_i = g;
    bus_b.clear_i = c; bus_b.mode_i = m; bus_b.set_i = s; bus_b.gate_i = g;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NUM_CH; k++) begin
        m_out[d][k] = 1'b0;
        m_age[d][k] = 0;
        m_cnt[d][k] = 0;
      end
  endtask

  // Flag is high while the condition holds and for hold_p cycles after it was last true.
  task automatic model_step();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < NUM_CH; k++) begin
        bit q;
        if (cur_clear) begin
          m_out[d][k] = 1'b0;
          m_age[d][k] = 0;
          m_cnt[d][k] = 0;
        end else begin
          q = cur_gate[k] && (cur_set[k] || (cur_mode[k] && m_out[d][k]));
          if (q) begin
            if (!m_out[d][k] && m_cnt[d][k] < cmax[d]) m_cnt[d][k] = m_cnt[d][k] + 1;
            m_out[d][k] = 1'b1;
            m_age[d][k] = 0;
          end else if (m_out[d][k]) begin
            m_age[d][k] = m_age[d][k] + 1;
            m_out[d][k] = (m_age[d][k] <= hold_p[d]);
          end
        end
      end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] exp_out(input int d);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) v[k] = m_out[d][k];
    return v;
  endfunction

  function automatic logic [31:0] exp_cnt(input int d, input int k);
    return CNT_ON ? 32'(m_cnt[d][k]) : 32'd0;
  endfunction

  task automatic check_all();
    check("a_out",  32'(bus_a.out_o), exp_out(0));
    check("a_any",  32'(bus_a.any_o), 32'(|exp_out(0)));
    check("a_cnt0", 32'(bus_a.evt_cnt_o[7:0]),  exp_cnt(0, 0));
    check("a_cnt1", 32'(bus_a.evt_cnt_o[15:8]), exp_cnt(0, 1));
    check("b_out",  32'(bus_b.out_o), exp_out(1));
    check("b_any",  32'(bus_b.any_o), 32'(|exp_out(1)));
    check("b_cnt0", 32'(bus_b.evt_cnt_o[1:0]), exp_cnt(1, 0));
    check("b_cnt1", 32'(bus_b.evt_cnt_o[3:2]), exp_cnt(1, 1));
  endtask

  // Synchronous-release reset pulse with inputs idle.
  task automatic reset_pulse();
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_and_drain(input int idle_cycles);
    drive(1'b0, 2'b00, 2'b01, 2'b01);
    tick();
    check_all();
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < idle_cycles; i++) begin
      tick();
      check_all();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    //              clr   mode   set    gate   out    c0     c1
    tbl[0]  = '{1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 8'd1, 8'd0};
    tbl[1]  = '{1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 8'd1, 8'd0};
    tbl[2]  = '{1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 8'd1, 8'd0};
    tbl[3]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 8'd1, 8'd0};
    tbl[4]  = '{1'b0, 2'b01, 2'b10, 2'b10, 2'b10, 8'd1, 8'd1};
    tbl[5]  = '{1'b0, 2'b01, 2'b10, 2'b10, 2'b10, 8'd1, 8'd1};
    tbl[6]  = '{1'b0, 2'b01, 2'b10, 2'b10, 2'b10, 8'd1, 8'd1};
    tbl[7]  = '{1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 8'd1, 8'd1};
    tbl[8]  = '{1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 8'd2, 8'd2};
    tbl[9]  = '{1'b1, 2'b00, 2'b11, 2'b11, 2'b00, 8'd0, 8'd0};
    tbl[10] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0, 8'd0};
    tbl[11] = '{1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 8'd1, 8'd0};
    tbl[12] = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 8'd1, 8'd0};

    drive(1'b0, 2'b00, 2'b00, 2'b00);
    model_reset();
    #12;
    check("rst_state_a", 32'(bus_a.dbg_state), 32'd0);
    check("rst_state_b", 32'(bus_b.dbg_state), 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Sticky capture, level mode, clear/set collision, mode switch.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].clear, tbl[i].mode, tbl[i].set, tbl[i].gate);
      tick();
      check($sformatf("tbl%0d_out", i), 32'(bus_a.out_o), 32'(tbl[i].exp_out));
      check($sformatf("tbl%0d_any", i), 32'(bus_a.any_o), 32'(|tbl[i].exp_out));
      check($sformatf("tbl%0d_c0", i), 32'(bus_a.evt_cnt_o[7:0]),  CNT_ON ? 32'(tbl[i].exp_c0) : 32'd0);
      check($sformatf("tbl%0d_c1", i), 32'(bus_a.evt_cnt_o[15:8]), CNT_ON ? 32'(tbl[i].exp_c1) : 32'd0);
      check_all();
    end

    // Hold-off on dut_b: flag stays exactly 3 cycles after the condition drops.
    reset_pulse();
    drive(1'b0, 2'b00, 2'b01, 2'b01);
    tick();
    check("hold_rise", 32'(bus_b.out_o[0]), 32'd1);
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_hi%0d", i), 32'(bus_b.out_o[0]), 32'd1);
      check($sformatf("hold_st%0d", i), 32'(bus_b.dbg_state[1:0]), 32'(HOLD));
    end
    tick();
    check("hold_fall", 32'(bus_b.out_o[0]), 32'd0);

    // Re-entry from HOLD keeps the flag and does not count.
    drive(1'b0, 2'b00, 2'b01, 2'b01);
    tick();
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    tick();
    drive(1'b0, 2'b00, 2'b01, 2'b01);
    tick();
    check("reent_out", 32'(bus_b.out_o[0]), 32'd1);
    check("reent_cnt", 32'(bus_b.evt_cnt_o[1:0]), CNT_ON ? 32'd2 : 32'd0);
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    check_all();

    // Three more captures: five in total, 2-bit counter saturates at 3.
    for (int p = 0; p < 3; p++) pulse_and_drain(5);
    check("sat_cnt", 32'(bus_b.evt_cnt_o[1:0]), CNT_ON ? 32'd3 : 32'd0);

    // Asynchronous reset between edges while ACTIVE (sticky).
    drive(1'b0, 2'b01, 2'b01, 2'b01);
    tick();
    check("pre_rst_out", 32'(bus_b.out_o[0]), 32'd1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_out_a", 32'(bus_a.out_o), 32'd0);
    check("arst_out_b", 32'(bus_b.out_o), 32'd0);
    check("arst_cnt_b", 32'(bus_b.evt_cnt_o), 32'd0);
    check("arst_cnt_a", 32'(bus_a.evt_cnt_o), 32'd0);
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("arst_resid", 32'(bus_b.out_o), 32'd0);

    // Asynchronous reset between edges while in HOLD.
    drive(1'b0, 2'b00, 2'b01, 2'b01);
    tick();
    drive(1'b0, 2'b00, 2'b00, 2'b00);
    tick();
    check("hold_pre_rst", 32'(bus_b.dbg_state[1:0]), 32'(HOLD));
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("hrst_out", 32'(bus_b.out_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("hrst_resid", 32'(bus_b.out_o), 32'd0);
    check_all();

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic       c;
      logic [1:0] m, s, g;
      c = ($urandom_range(0, 31) == 0);
      m = 2'($urandom_range(0, 3));
      s = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      g = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      drive(c, m, s, g);
      tick();
      check_all();
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/injection_latch_array.md
Name: injection_latch_array

Overview:
- Parametrised N-channel injection latch.
- Each channel registers a fault/injection flag from a set request qualified by a gate condition.
- Per-channel mode: sticky (self-holding while gated) or level (follows set & gate).
- Optional programmable hold-off after gate loss, a global synchronous clear, and per-channel saturating event counters.
- Sits between injection trigger logic and the fault-propagation/observation outputs.

Parameters:
- NUM_CH, 2, number of independent channels (>=1).
- HOLD_CYCLES, 0, extra cycles the flag stays high after the qualifying condition drops (0 = clear on the next edge).
- CNT_W, 8, width of each per-channel event counter (>=1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear_i  input  1  synchronous clear of all channel states and counters.
- mode_i  input  NUM_CH  per channel: 1 = sticky, 0 = level.
- set_i  input  NUM_CH  per-channel set request.
- gate_i  input  NUM_CH  per-channel qualifying condition.
- out_o  output  NUM_CH  registered injection flag per channel.
- any_o  output  1  OR-reduction of out_o (combinational from registers, no added latency).
- evt_cnt_o  output  NUM_CH*CNT_W  per-channel event counters, channel k at bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset (rst=1, asynchronous): all channels IDLE, hold counters 0, event counters 0, out_o=0, any_o=0.
- Reset asserted mid-hold or mid-active aborts immediately; there is no residual output after release.
- Latency: out_o is the registered state; it rises on the first clk edge where the condition is sampled true.
- Each channel runs its own FSM (IDLE, ACTIVE, HOLD); out_o[k] = (state != IDLE).
- Qualify term: q = gate_i & (set_i | (mode_i & out_o)).
  - Sticky mode: a raised flag holds itself while gate_i is high.
  - Level mode: set_i & gate_i is required every cycle.
- IDLE:
  - q=1 -> ACTIVE.
  - Otherwise stay IDLE.
- ACTIVE:
  - q=1 -> stay ACTIVE.
  - q=0 and HOLD_CYCLES==0 -> IDLE.
  - q=0 and HOLD_CYCLES>0 -> HOLD, with hold_cnt loaded to HOLD_CYCLES-1.
- HOLD:
  - q=1 (evaluated with out_o=1) -> ACTIVE; the hold count is discarded.
  - Else hold_cnt==0 -> IDLE.
  - Else hold_cnt decrements.
  - Result: the flag stays high exactly HOLD_CYCLES cycles after the first cycle with q=0.
- mode_i is sampled every cycle; a switch from sticky to level while ACTIVE with set_i=0 behaves as q=0.
- clear_i=1: all channels go to IDLE and all counters to 0 on that edge. clear_i has priority over set_i/gate_i in the same cycle.
- Event counter: increments by 1 on each IDLE->ACTIVE transition only.
  - HOLD->ACTIVE re-entry does not count.
  - Saturates at 2^CNT_W-1, no wrap.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Hold counter width = max(1, clog2(HOLD_CYCLES+1)).

Optional Feature:
- Macro INJ_EVT_CNT_EN.
- Defined: event counters are implemented as specified.
- Undefined: no counter registers; evt_cnt_o is tied to 0. All other behaviour is identical.

Decomposition:
- Shared package injection_pkg:
  - State enum typedef inj_state_t (IDLE=2'd0, ACTIVE=2'd1, HOLD=2'd2).
  - Function clog2_min1 used to size the hold counter.
- Sub-module injection_channel: one channel's FSM, hold counter and event counter, with scalar ports plus a CNT_W counter output.
- Top generates NUM_CH instances and derives any_o.

Test Plan:
1. Reset and sticky capture:
   - Stimulus: NUM_CH=2, HOLD_CYCLES=0; rst pulse; channel 0 sticky; gate_i=1; set_i[0]=1 for one cycle, then 0.
   - Response: out_o[0] rises one edge after the set cycle, stays 1 while gate_i=1, falls on the edge after gate_i drops; evt_cnt_o[7:0]=1.
2. Level mode:
   - Stimulus: channel 1 level; set_i[1]=1 with gate_i[1]=1 for 3 cycles, then set_i[1]=0.
   - Response: out_o[1] high exactly 3 cycles, 1-cycle delayed; count=1.
3. Hold-off:
   - Stimulus: HOLD_CYCLES=3; channel active; gate drops at cycle t.
   - Response: out_o stays 1 for 3 more cycles, then 0. Re-asserting gate+set during HOLD keeps out_o high with no counter increment.
4. Clear vs set collision:
   - Stimulus: clear_i=1 in the same cycle as set_i=2'b11, gate_i=2'b11.
   - Response: out_o=0 and counters=0 after that edge.
5. Saturation and async reset:
   - Stimulus: CNT_W=2; 5 separate set pulses.
   - Response: counter reads 3 and holds.
   - Then assert rst between clock edges: out_o and counters go to 0 immediately.
6. Macro off:
   - Stimulus: build without INJ_EVT_CNT_EN; repeat scenario 1.
   - Response: identical out_o/any_o; evt_cnt_o=0 throughout.
